fir_result_serializer: RTL and testbench



---
 rtl/fir_result_serializer.sv | 179 +++++++++++++++++
 tb/tb_fir_result_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_result_serializer.sv
// Buffers completed FIR frames in a small FIFO, rescales each 32-bit result to a
// saturated 16-bit sample and streams the samples out on a valid/ready handshake.
module fir_result_serializer #(
    parameter int SAMPLES_NUM = 4,
    parameter int SHIFT       = 15,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      doneIn,
    input  logic [32*SAMPLES_NUM-1:0] dataIn,
    output logic                      holdOut,
    output logic [15:0]               sampleOut,
    output logic                      validOut,
    input  logic                      readyIn,
    output logic                      lastOut,
    output logic                      overflowOut,
    output logic [15:0]               clipCountOut
);
    localparam int FRAME_W = 32 * SAMPLES_NUM;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LANE_W  = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    localparam logic [LANE_W-1:0]    LAST_LANE  = LANE_W'(SAMPLES_NUM - 1);
    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic signed [33:0]   ROUND      = (34'sd1 <<< SHIFT) >>> 1;

    typedef enum logic {ST_IDLE, ST_EMIT} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [FRAME_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_count_next;
    logic [FRAME_W-1:0]   r_frame;
    logic [FRAME_W-1:0]   w_head;
    logic [LANE_W-1:0]    r_lane;
    logic [LANE_W-1:0]    w_next_lane;
    logic [15:0]          r_sample;
    logic                 r_valid;
    logic                 r_hold;
    logic                 r_overflow;
    logic [15:0]          r_clip_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_load_head;
    logic                 w_load_next;
    logic                 w_drop_valid;
    logic [16:0]          w_conv;

    // Lane 0 sits in the most significant 32 bits of a frame.
    function automatic logic [31:0] f_lane(input logic [FRAME_W-1:0] frame,
                                           input logic [LANE_W-1:0]  idx);
        return frame[32*(SAMPLES_NUM-1-int'(idx)) +: 32];
    endfunction

    // Returns {clipped, sample}: round half up, arithmetic shift, saturate to 16 bits.
    function automatic logic [16:0] f_convert(input logic [31:0] x);
        logic signed [33:0] v;
        logic signed [33:0] y;
        v = signed'({{2{x[31]}}, x}) + ROUND;
        y = v >>> SHIFT;
        if (y > 34'sd32767)
            return {1'b1, 16'h7FFF};
        else if (y < -34'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, y[15:0]};
    endfunction

    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clkIn) begin
        if (resetIn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load_head  = 1'b0;
        w_load_next  = 1'b0;
        w_drop_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_load_head  = 1'b1;
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (readyIn) begin
                    if (r_lane != LAST_LANE) begin
                        w_load_next = 1'b1;
                    end else if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_load_head = 1'b1;
                    end else begin
                        w_drop_valid = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push       = doneIn && ((r_count != FULL_COUNT) || w_pop);
        w_count_next = r_count;
        if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
        w_next_lane = (r_lane == LAST_LANE) ? '0 : r_lane + LANE_W'(1);
        w_conv      = f_convert(w_load_head ? f_lane(w_head, '0) : f_lane(r_frame, w_next_lane));
    end

    // NOTE: frame storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clkIn) begin
        if (w_push)
            r_mem[r_wr_ptr] <= dataIn;
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_frame      <= '0;
            r_lane       <= '0;
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_hold       <= 1'b0;
            r_overflow   <= 1'b0;
            r_clip_count <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_frame  <= w_head;
            end
            r_count <= w_count_next;
            r_hold  <= (w_count_next == FULL_COUNT);
            if (doneIn && !w_push)
                r_overflow <= 1'b1;

            if (w_load_head) begin
                r_sample <= w_conv[15:0];
                r_valid  <= 1'b1;
                r_lane   <= '0;
            end else if (w_load_next) begin
                r_sample <= w_conv[15:0];
                r_lane   <= w_next_lane;
            end else if (w_drop_valid) begin
                r_valid  <= 1'b0;
            end

            if ((w_load_head || w_load_next) && w_conv[16] && (r_clip_count != 16'hFFFF))
                r_clip_count <= r_clip_count + 16'd1;
        end
    end

    assign holdOut      = r_hold;
    assign sampleOut    = r_sample;
    assign validOut     = r_valid;
    assign lastOut      = r_valid && (r_lane == LAST_LANE);
    assign overflowOut  = r_overflow;
    assign clipCountOut = r_clip_count;

endmodule

// File: tb/tb_fir_result_serializer.sv
// Scoreboard bench for fir_result_serializer: stimulus pushes expected samples,
// a negedge monitor compares whatever the DUT presents.
module tb_fir_result_serializer;
    localparam int SN    = 4;
    localparam int SH    = 15;
    localparam int DEPTH = 2;

    logic                clkIn = 1'b0;
    logic                resetIn;
    logic                doneIn;
    logic [32*SN-1:0]    dataIn;
    logic                holdOut;
    logic [15:0]         sampleOut;
    logic                validOut;
    logic                readyIn;
    logic                lastOut;
    logic                overflowOut;
    logic [15:0]         clipCountOut;

    fir_result_serializer #(.SAMPLES_NUM(SN), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) dut (
        .clkIn(clkIn), .resetIn(resetIn), .doneIn(doneIn), .dataIn(dataIn),
        .holdOut(holdOut), .sampleOut(sampleOut), .validOut(validOut), .readyIn(readyIn),
        .lastOut(lastOut), .overflowOut(overflowOut), .clipCountOut(clipCountOut)
    );

    always #5 clkIn = ~clkIn;

    typedef struct {
        logic [15:0] sample;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   exp_clip   = 0;
    int   issued     = 0;
    int   completed  = 0;
    int   ready_mode = 3;   // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: always 0
    int   rphase     = 0;
    bit   mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // Reference rescale: floor((x + 2^(SH-1)) / 2^SH), clamped to the int16 range.
    function automatic logic [15:0] ref_conv(input logic [31:0] x, output bit clipped);
        longint v;
        v = longint'($signed(x));
        if (SH > 0)
            v = v + (longint'(1) << (SH - 1));
        v = v >>> SH;
        clipped = 1'b1;
        if (v > 32767)
            return 16'h7FFF;
        if (v < -32768)
            return 16'h8000;
        clipped = 1'b0;
        return v[15:0];
    endfunction

    task automatic issue_frame(input logic [32*SN-1:0] d, input bit accept);
        exp_t e;
        bit   c;
        dataIn = d;
        doneIn = 1'b1;
        if (accept) begin
            for (int i = 0; i < SN; i++) begin
                e.sample = ref_conv(d[32*(SN-1-i) +: 32], c);
                e.last   = (i == SN - 1);
                exp_q.push_back(e);
                if (c)
                    exp_clip++;
            end
            issued++;
        end
        tick();
        doneIn = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0)
                break;
            tick();
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (4) tick();
    endtask

    function automatic logic [31:0] rand_lane();
        logic [31:0] edges [6];
        logic [31:0] r;
        edges[0] = 32'h00004000; edges[1] = 32'hFFFFBFFF; edges[2] = 32'h3FFFBFFF;
        edges[3] = 32'h3FFFC000; edges[4] = 32'hC0000000; edges[5] = 32'hBFFFBFFF;
        r = $urandom();
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{12{r[19]}}, r[19:0]};
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    always @(posedge clkIn) begin
        #1;
        case (ready_mode)
            0: readyIn = 1'b1;
            1: begin
                readyIn = (rphase % 3 == 0);
                rphase++;
            end
            2: readyIn = 1'($urandom_range(0, 1));
            default: readyIn = 1'b0;
        endcase
    end

    always @(negedge clkIn) begin
        exp_t e;
        if (mon_en && !resetIn) begin
            if (validOut) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(validOut), 0);
                end else begin
                    e = exp_q[0];
                    check("sample", 32'(sampleOut), 32'(e.sample));
                    check("last", 32'(lastOut), 32'(e.last));
                    if (readyIn) begin
                        void'(exp_q.pop_front());
                        if (e.last)
                            completed++;
                    end
                end
            end else begin
                check("last_while_idle", 32'(lastOut), 0);
            end
        end
    end

    initial begin
        logic [32*SN-1:0] d;
        int  run;
        bit  any;
        bit  timed_out;

        resetIn = 1'b1; doneIn = 1'b0; readyIn = 1'b0; dataIn = '0;
        repeat (3) tick();
        check("rst_valid", 32'(validOut), 0);
        check("rst_sample", 32'(sampleOut), 0);
        check("rst_last", 32'(lastOut), 0);
        check("rst_hold", 32'(holdOut), 0);
        check("rst_overflow", 32'(overflowOut), 0);
        check("rst_clip", 32'(clipCountOut), 0);
        resetIn = 1'b0;
        mon_en  = 1'b1;

        // Basic frame and two-cycle latency
        ready_mode = 0;
        tick();
        issue_frame({32'h00004000, 32'h3FFF8000, 32'hFFFFC000, 32'hFFFFBFFF}, 1'b1);
        check("latency_n1_valid", 32'(validOut), 0);
        tick();
        check("latency_n2_valid", 32'(validOut), 1);
        check("latency_n2_sample", 32'(sampleOut), 32'h0001);
        drain(50);
        check("clip_basic", 32'(clipCountOut), 32'(exp_clip));

        // Saturation
        issue_frame({32'h40000000, 32'h80000000, 32'h7FFFFFFF, 32'h00000000}, 1'b1);
        drain(50);
        check("clip_sat", 32'(clipCountOut), 3);
        check("clip_sat_model", 32'(clipCountOut), 32'(exp_clip));

        // Backpressure
        ready_mode = 1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < SN; i++)
                d[32*i +: 32] = rand_lane();
            issue_frame(d, 1'b1);
        end
        drain(200);

        // FIFO fill and overflow with the consumer stalled
        ready_mode = 3;
        repeat (2) tick();
        issue_frame({32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000}, 1'b1);
        repeat (9) tick();
        check("ovf_first_popped_valid", 32'(validOut), 1);
        check("ovf_hold_after_1", 32'(holdOut), 0);
        issue_frame({32'h00050000, 32'h00060000, 32'h00070000, 32'h00080000}, 1'b1);
        repeat (9) tick();
        check("ovf_hold_after_2", 32'(holdOut), 0);
        issue_frame({32'hFFFF0000, 32'hFFFE0000, 32'hFFFD0000, 32'hFFFC0000}, 1'b1);
        check("ovf_hold_after_3", 32'(holdOut), 1);
        check("ovf_flag_before_4", 32'(overflowOut), 0);
        repeat (9) tick();
        issue_frame({32'h12340000, 32'h56780000, 32'h11110000, 32'h22220000}, 1'b0);
        check("ovf_flag_after_4", 32'(overflowOut), 1);
        check("ovf_hold_after_4", 32'(holdOut), 1);
        ready_mode = 0;
        drain(100);
        repeat (10) tick();
        check("ovf_hold_drained", 32'(holdOut), 0);
        check("ovf_flag_sticky", 32'(overflowOut), 1);
        check("ovf_clip", 32'(clipCountOut), 32'(exp_clip));

        // Back-to-back frames: eight consecutive valid cycles
        issue_frame({32'h00008000, 32'h00010000, 32'h00018000, 32'h00020000}, 1'b1);
        issue_frame({32'hFFFF8000, 32'hFFFF0000, 32'hFFFE8000, 32'hFFFE0000}, 1'b1);
        timed_out = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (validOut) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        check("b2b_valid_seen", 32'(timed_out), 0);
        run = 0;
        while (validOut && run < 20) begin
            run++;
            tick();
        end
        check("b2b_run_length", 32'(run), 8);
        drain(50);

        // Reset mid-frame with one frame queued
        ready_mode = 3;
        tick();
        issue_frame({32'h40000000, 32'h00004000, 32'h00008000, 32'h0000C000}, 1'b1);
        repeat (4) tick();
        issue_frame({32'h00010000, 32'h00014000, 32'h00018000, 32'h0001C000}, 1'b1);
        repeat (3) tick();
        check("pre_reset_valid", 32'(validOut), 1);
        check("pre_reset_clip_nonzero", 32'(clipCountOut != 0), 1);
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        exp_q.delete();
        exp_clip = 0; issued = 0; completed = 0;
        check("mid_rst_valid", 32'(validOut), 0);
        check("mid_rst_hold", 32'(holdOut), 0);
        check("mid_rst_clip", 32'(clipCountOut), 0);
        check("mid_rst_overflow", 32'(overflowOut), 0);
        check("mid_rst_last", 32'(lastOut), 0);
        ready_mode = 0;
        any = 1'b0;
        repeat (20) begin
            tick();
            if (validOut)
                any = 1'b1;
        end
        check("no_output_after_reset", 32'(any), 0);

        // Randomized traffic with random backpressure
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            timed_out = 1'b1;
            for (int w = 0; w < 300; w++) begin
                if (issued - completed < DEPTH) begin
                    timed_out = 1'b0;
                    break;
                end
                tick();
            end
            if (timed_out) begin
                check("rand_room_timeout", 32'(issued - completed), 32'(DEPTH - 1));
                break;
            end
            for (int i = 0; i < SN; i++)
                d[32*i +: 32] = rand_lane();
            issue_frame(d, 1'b1);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain(3000);
        check("rand_clip", 32'(clipCountOut), 32'(exp_clip));
        check("rand_overflow", 32'(overflowOut), 0);
        check("rand_hold", 32'(holdOut), 0);
        check("rand_frames_done", 32'(completed), 32'(issued));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
